// File: rtl/pinwheel_mem_pkg.sv
// Shared types and constants for the pinwheel data-memory arbiter.
package pinwheel_mem_pkg;

    localparam int WORD_W     = 32;
    localparam int MASK_W     = 4;
    localparam int ADDR_MAX_W = 32;

    // One requester's access as seen by the arbiter; addr is zero-extended.
    typedef struct packed {
        logic [ADDR_MAX_W-1:0] addr;
        logic [WORD_W-1:0]     wdata;
        logic [MASK_W-1:0]     wmask;
        logic                  lock;
    } mem_req_t;

    typedef enum logic {
        ARB_IDLE,
        ARB_LOCKED
    } arb_state_e;

    // Increment with wrap at n; used for the round-robin pointer.
    function automatic int wrap_inc(input int v, input int n);
        return (v + 1 >= n) ? 0 : v + 1;
    endfunction

endpackage

// File: rtl/pinwheel_rr_pick.sv
// Combinational rotating-priority picker: the search starts at ptr and wraps,
// returning a one-hot grant, its index, and whether anything was granted.
module pinwheel_rr_pick #(
    parameter int N     = 4,
    parameter int PTR_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [PTR_W-1:0] grant_idx,
    output logic             any
);

    // Walk the ports starting at ptr and take the first requesting one.
    always_comb begin
        int idx;
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        idx       = 0;
        for (int i = 0; i < N; i++) begin
            idx = (int'(ptr) + i) % N;
            if (!any && req[idx]) begin
                grant[idx] = 1'b1;
                grant_idx  = PTR_W'(idx);
                any        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pinwheel_mem_arbiter.sv
// Shares one single-port data BRAM among NPORTS requesters, one grant per
// cycle, with a lock for read-modify-write sequences.
// Build option: PINWHEEL_MEM_ARB_FIXED_PRIO_EN selects fixed priority
// (lowest index wins) instead of round-robin; locking is unaffected.
module pinwheel_mem_arbiter
    import pinwheel_mem_pkg::*;
#(
    parameter int NPORTS = 4,
    parameter int DEPTH  = 256,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NPORTS-1:0]        req_valid,
    output logic [NPORTS-1:0]        req_ready,
    input  logic [NPORTS*ADDR_W-1:0] req_addr,
    input  logic [NPORTS*WORD_W-1:0] req_wdata,
    input  logic [NPORTS*MASK_W-1:0] req_wmask,
    input  logic [NPORTS-1:0]        req_lock,
    output logic [NPORTS-1:0]        resp_valid,
    output logic [WORD_W-1:0]        resp_rdata,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [WORD_W-1:0]        mem_wdata,
    output logic [MASK_W-1:0]        mem_wmask,
    input  logic [WORD_W-1:0]        mem_rdata
);

    localparam int PTR_W = $clog2(NPORTS);

    arb_state_e        state, state_next;
    logic [PTR_W-1:0]  owner, owner_next;
    logic [PTR_W-1:0]  rr_ptr;
    logic [NPORTS-1:0] eligible;
    logic [NPORTS-1:0] grant;
    logic [PTR_W-1:0]  grant_idx;
    logic              grant_any;
    logic              release_lock;
    logic [NPORTS-1:0] resp_port;
    logic              resp_read;
    mem_req_t          reqs [NPORTS];
    mem_req_t          sel;
    logic              unused_addr_hi;

    // Unpack the flat request buses into one struct per port.
    always_comb begin
        reqs = '{default: '0};
        for (int p = 0; p < NPORTS; p++) begin
            reqs[p].addr  = ADDR_MAX_W'(req_addr[p*ADDR_W +: ADDR_W]);
            reqs[p].wdata = req_wdata[p*WORD_W +: WORD_W];
            reqs[p].wmask = req_wmask[p*MASK_W +: MASK_W];
            reqs[p].lock  = req_lock[p];
        end
    end

    // While locked only the owner may compete; nobody is granted in reset.
    always_comb begin
        eligible = '0;
        if (!reset) begin
            if (state == ARB_IDLE)
                eligible = req_valid;
            else
                eligible = req_valid & (NPORTS'(1) << owner);
        end
    end

    pinwheel_rr_pick #(
        .N     (NPORTS),
        .PTR_W (PTR_W)
    ) u_pick (
        .req       (eligible),
        .ptr       (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any       (grant_any)
    );

    assign req_ready      = grant;
    assign sel            = reqs[grant_idx];
    assign unused_addr_hi = |sel.addr[ADDR_MAX_W-1:ADDR_W];

    // The owner releases by an unlocked grant or by dropping valid and lock together.
    assign release_lock = (state == ARB_LOCKED) &&
                          ((grant_any && !sel.lock) ||
                           (!req_valid[owner] && !req_lock[owner]));

    // Route the granted port to the RAM; with no grant the RAM sees a harmless read of 0.
    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wmask = '0;
        if (grant_any) begin
            mem_addr  = sel.addr[ADDR_W-1:0];
            mem_wdata = sel.wdata;
            mem_wmask = sel.wmask;
        end
    end

    // Next-state logic for the lock state machine.
    always_comb begin
        state_next = state;
        owner_next = owner;
        case (state)
            ARB_IDLE: begin
                if (grant_any && sel.lock) begin
                    state_next = ARB_LOCKED;
                    owner_next = grant_idx;
                end
            end
            ARB_LOCKED: begin
                if (release_lock)
                    state_next = ARB_IDLE;
            end
            default: state_next = ARB_IDLE;
        endcase
    end

    // State, owner and the one-cycle response tracking registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= ARB_IDLE;
            owner     <= '0;
            resp_port <= '0;
            resp_read <= 1'b0;
        end else begin
            state     <= state_next;
            owner     <= owner_next;
            resp_port <= grant;
            resp_read <= grant_any && (sel.wmask == '0);
        end
    end

`ifdef PINWHEEL_MEM_ARB_FIXED_PRIO_EN
    assign rr_ptr = '0;
`else
    // Pointer moves past an unlocked grant, and past the owner on lock release.
    always_ff @(posedge clock) begin
        if (reset)
            rr_ptr <= '0;
        else if (state == ARB_IDLE && grant_any && !sel.lock)
            rr_ptr <= PTR_W'(wrap_inc(int'(grant_idx), NPORTS));
        else if (release_lock)
            rr_ptr <= PTR_W'(wrap_inc(int'(owner), NPORTS));
    end
`endif

    // Responses are suppressed while reset is held; write acks carry zero data.
    assign resp_valid = reset ? '0 : resp_port;
    assign resp_rdata = (!reset && (|resp_port) && resp_read) ? mem_rdata : '0;

endmodule
